// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared mode constants and sizing helper for the timer bank
//
// Purpose : constants and helper functions shared by timer_channel and timer_bank.
// Contents: TIMER_ONESHOT / TIMER_PERIODIC mode encodings,
//           pre_width() - prescaler counter width (clog2, minimum 1 bit).
package timer_pkg;

  localparam logic TIMER_ONESHOT  = 1'b0;
  localparam logic TIMER_PERIODIC = 1'b1;

  // A prescale of 1 still needs a 1-bit register so the channel logic stays uniform.
  function automatic int pre_width(input int prescale);
    return (prescale <= 1) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one prescaled down-time timer channel
//
// Purpose : single independent timer with prescaler, one-shot/periodic mode,
//           restart and stop.
// Ports   : clk, rst        - clock, asynchronous active-high reset
//           init_val[W]     - load value, sampled on start
//           periodic        - mode, sampled on start
//           start, stop     - launch/restart and abort requests
//           ovf             - registered one-cycle expiry pulse
//           busy            - channel running
//           count[W]        - current tick count
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH    = 5,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] init_val,
  input  logic             periodic,
  input  logic             start,
  input  logic             stop,
  output logic             ovf,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  localparam int             PW       = pre_width(PRESCALE);
  localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] load_q, load_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;

  logic tick;
  logic expire;

  // Expiry is judged on pre-edge state so a coincident start/stop never
  // swallows the overflow pulse.
  assign tick   = busy_q && (pre_q == PRE_LAST);
  assign expire = tick && (cnt_q == load_q);

  always_comb begin
    load_d = load_q;
    mode_d = mode_q;
    cnt_d  = cnt_q;
    pre_d  = pre_q;
    busy_d = busy_q;
    ovf_d  = expire;

    if (busy_q) begin
      if (tick) begin
        pre_d = '0;
        if (expire) begin
          cnt_d = '0;
          if (mode_q == TIMER_ONESHOT) begin
            busy_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end

    // Stop freezes the pre-edge count so software can read where it halted.
    if (stop && busy_q) begin
      busy_d = 1'b0;
      cnt_d  = cnt_q;
      pre_d  = pre_q;
    end

    // Start wins over everything, including a simultaneous stop (restart).
    if (start) begin
      load_d = init_val;
      mode_d = periodic;
      cnt_d  = '0;
      pre_d  = '0;
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q <= '0;
      mode_q <= TIMER_ONESHOT;
      cnt_q  <= '0;
      pre_q  <= '0;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      load_q <= load_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      pre_q  <= pre_d;
      busy_q <= busy_d;
      ovf_q  <= ovf_d;
    end
  end

  assign ovf   = ovf_q;
  assign busy  = busy_q;
  assign count = cnt_q;

endmodule

// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - bank of independent prescaled timer channels
//
// Purpose : CHANNELS independent timer_channel instances sharing clock and reset.
// Ports   : Clk, Reset          - clock, asynchronous active-high reset
//           Initial[C*W]        - per-channel load value, channel i at [i*W +: W]
//           Periodic[C]         - per-channel mode (0 one-shot, 1 periodic)
//           Start[C], Stop[C]   - per-channel launch/restart and abort
//           Ovf[C]              - registered one-cycle expiry pulses
//           Busy[C]             - channel running flags
//           Count[C*W]          - per-channel tick counts
module timer_bank
  import timer_pkg::*;
#(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 2,
  parameter int PRESCALE = 1
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [CHANNELS*WIDTH-1:0] Initial,
  input  logic [CHANNELS-1:0]       Periodic,
  input  logic [CHANNELS-1:0]       Start,
  input  logic [CHANNELS-1:0]       Stop,
  output logic [CHANNELS-1:0]       Ovf,
  output logic [CHANNELS-1:0]       Busy,
  output logic [CHANNELS*WIDTH-1:0] Count
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    timer_channel #(
      .WIDTH    (WIDTH),
      .PRESCALE (PRESCALE)
    ) u_ch (
      .clk      (Clk),
      .rst      (Reset),
      .init_val (Initial[i*WIDTH +: WIDTH]),
      .periodic (Periodic[i]),
      .start    (Start[i]),
      .stop     (Stop[i]),
      .ovf      (Ovf[i]),
      .busy     (Busy[i]),
      .count    (Count[i*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_timer_bank.sv
// tb/tb_timer_bank.sv - directed self-checking bench for timer_bank
module tb_timer_bank;

  logic       Clk;
  logic       Reset;
  logic [9:0] init_a, init_b;
  logic [1:0] per_a, per_b, start_a, start_b, stop_a, stop_b;
  logic [1:0] ovf_a, ovf_b, busy_a, busy_b;
  logic [9:0] count_a, count_b;

  int n_assert;
  int n_fail;

  timer_bank #(.WIDTH(5), .CHANNELS(2), .PRESCALE(1)) dut_a (
    .Clk(Clk), .Reset(Reset), .Initial(init_a), .Periodic(per_a),
    .Start(start_a), .Stop(stop_a), .Ovf(ovf_a), .Busy(busy_a), .Count(count_a)
  );

  timer_bank #(.WIDTH(5), .CHANNELS(2), .PRESCALE(4)) dut_b (
    .Clk(Clk), .Reset(Reset), .Initial(init_b), .Periodic(per_b),
    .Start(start_b), .Stop(stop_b), .Ovf(ovf_b), .Busy(busy_b), .Count(count_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    Reset    = 1'b1;
    init_a = '0; init_b = '0; per_a = '0; per_b = '0;
    start_a = '0; start_b = '0; stop_a = '0; stop_b = '0;

    // Reset state
    step();
    check("rst ovf_a", 32'(ovf_a), 0);
    check("rst busy_a", 32'(busy_a), 0);
    check("rst count_a", 32'(count_a), 0);
    check("rst busy_b", 32'(busy_b), 0);
    step();
    Reset = 1'b0;
    step();

    // One-shot Initial=5 on ch0, ch1 idle
    init_a[4:0] = 5'd5; per_a[0] = 1'b0; start_a[0] = 1'b1;
    step(); start_a[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("os5 ovf0 E%0d", k), 32'(ovf_a[0]), 32'(k == 6));
      check($sformatf("os5 busy0 E%0d", k), 32'(busy_a[0]), 32'(k < 6));
      check($sformatf("os5 cnt0 E%0d", k), 32'(count_a[4:0]), (k < 6) ? k : 0);
      check($sformatf("os5 ovf1 E%0d", k), 32'(ovf_a[1]), 0);
    end

    // Periodic Initial=3 on ch1
    init_a[9:5] = 5'd3; per_a[1] = 1'b1; start_a[1] = 1'b1;
    step(); start_a[1] = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      step();
      check($sformatf("per3 ovf1 E%0d", k), 32'(ovf_a[1]), 32'(k % 4 == 0));
      check($sformatf("per3 busy1 E%0d", k), 32'(busy_a[1]), 1);
    end
    stop_a[1] = 1'b1;
    step(); stop_a[1] = 1'b0;
    check("per3 stop busy1", 32'(busy_a[1]), 0);
    check("per3 stop cnt1", 32'(count_a[9:5]), 1);

    // Periodic Initial=0 on ch0: overflow every cycle
    init_a[4:0] = 5'd0; per_a[0] = 1'b1; start_a[0] = 1'b1;
    step(); start_a[0] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("per0 ovf0 E%0d", k), 32'(ovf_a[0]), 1);
      check($sformatf("per0 busy0 E%0d", k), 32'(busy_a[0]), 1);
    end
    stop_a[0] = 1'b1;
    step(); stop_a[0] = 1'b0;
    step();
    check("per0 after stop ovf0", 32'(ovf_a[0]), 0);

    // One-shot Initial=31 (max) on ch0
    init_a[4:0] = 5'd31; per_a[0] = 1'b0; start_a[0] = 1'b1;
    step(); start_a[0] = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      step();
      check($sformatf("os31 ovf0 E%0d", k), 32'(ovf_a[0]), 32'(k == 32));
      check($sformatf("os31 busy0 E%0d", k), 32'(busy_a[0]), 32'(k < 32));
    end

    // PRESCALE=4, one-shot Initial=2
    init_b[4:0] = 5'd2; per_b[0] = 1'b0; start_b[0] = 1'b1;
    step(); start_b[0] = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      step();
      check($sformatf("ps4 ovf0 E%0d", k), 32'(ovf_b[0]), 32'(k == 12));
      check($sformatf("ps4 cnt0 E%0d", k), 32'(count_b[4:0]),
            (k < 4) ? 0 : (k < 8) ? 1 : (k < 12) ? 2 : 0);
    end

    // Stop mid-run then relaunch
    init_a[4:0] = 5'd10; start_a[0] = 1'b1;
    step(); start_a[0] = 1'b0;
    step(); step();
    stop_a[0] = 1'b1;
    step(); stop_a[0] = 1'b0;
    check("stop busy0 E3", 32'(busy_a[0]), 0);
    check("stop cnt0 E3", 32'(count_a[4:0]), 2);
    check("stop ovf0 E3", 32'(ovf_a[0]), 0);
    step();
    check("stop cnt0 E4", 32'(count_a[4:0]), 2);
    check("stop ovf0 E4", 32'(ovf_a[0]), 0);
    init_a[4:0] = 5'd1; start_a[0] = 1'b1;
    step(); start_a[0] = 1'b0;
    step();
    check("relaunch ovf0 E6", 32'(ovf_a[0]), 0);
    check("relaunch cnt0 E6", 32'(count_a[4:0]), 1);
    step();
    check("relaunch ovf0 E7", 32'(ovf_a[0]), 1);

    // Restart on ch0; ch1 ignores mid-run Initial change
    init_a = {5'd6, 5'd6}; per_a = 2'b00; start_a = 2'b11;
    step(); start_a = 2'b00;
    init_a = {5'd20, 5'd20};
    for (int k = 1; k <= 8; k++) begin
      if (k == 4) begin
        init_a[4:0] = 5'd2; start_a[0] = 1'b1;
      end
      step();
      start_a[0] = 1'b0;
      check($sformatf("rs cnt0 E%0d", k), 32'(count_a[4:0]),
            (k < 4) ? k : (k == 4) ? 0 : (k < 7) ? k - 4 : 0);
      check($sformatf("rs ovf0 E%0d", k), 32'(ovf_a[0]), 32'(k == 7));
      check($sformatf("ign cnt1 E%0d", k), 32'(count_a[9:5]), (k < 7) ? k : 0);
      check($sformatf("ign ovf1 E%0d", k), 32'(ovf_a[1]), 32'(k == 7));
    end

    // Start coincident with expiry
    init_a[4:0] = 5'd1; start_a[0] = 1'b1;
    step(); start_a[0] = 1'b0;
    step();
    init_a[4:0] = 5'd3; start_a[0] = 1'b1;
    step(); start_a[0] = 1'b0;
    check("coin ovf0 E2", 32'(ovf_a[0]), 1);
    check("coin busy0 E2", 32'(busy_a[0]), 1);
    check("coin cnt0 E2", 32'(count_a[4:0]), 0);
    for (int k = 3; k <= 6; k++) begin
      step();
      check($sformatf("coin ovf0 E%0d", k), 32'(ovf_a[0]), 32'(k == 6));
    end

    // Asynchronous reset mid-run
    init_a = {5'd0, 5'd10}; per_a = 2'b10; start_a = 2'b11;
    step(); start_a = 2'b00;
    step(); step(); step();
    check("pre-rst cnt0", 32'(count_a[4:0]), 3);
    check("pre-rst ovf1", 32'(ovf_a[1]), 1);
    Reset = 1'b1;
    #2;
    check("async rst ovf", 32'(ovf_a), 0);
    check("async rst busy", 32'(busy_a), 0);
    check("async rst count", 32'(count_a), 0);
    step();
    Reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      check($sformatf("post-rst ovf E%0d", k), 32'(ovf_a), 0);
      check($sformatf("post-rst busy E%0d", k), 32'(busy_a), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
